hex_word_tx: RTL and testbench

Serialises one DATA_W-bit word per handshake into ASCII hex digits, MSB nibble first, for the 8-bit UART transmitter. Sits between any data producer (UART receiver, counters, debug taps) and `uart_tx`, and owns the `uart_tx_en` / `uart_tx_busy` handshake. It replaces the hard-wired two-digit byte echo FSM with a parametrised word formatter that has a ready/valid input, optional lowercase output, optional leading-zero suppression and an optional line terminator.

---
 rtl/hex_word_tx.sv | 161 ++++++++++++++++
 tb/tb_hex_word_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hex_word_tx.sv
// hex_word_tx: turns one DATA_W-bit word per ready/valid handshake into ASCII hex
// characters, MSB nibble first, driving a byte UART transmitter. Define HEX_WORD_TX_CRLF_EN for a CR/LF terminator.
module hex_word_tx #(
    parameter int DATA_W         = 8,
    parameter int LOWER          = 0,
    parameter int SUPPRESS_ZEROS = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [7:0]        tx_data,
    output logic              tx_en,
    input  logic              tx_busy,
    output logic              idle
);

    localparam int NCHARS = DATA_W / 4;
    localparam int IDX_W  = $clog2(NCHARS + 2);
`ifdef HEX_WORD_TX_CRLF_EN
    localparam int LAST_CHAR = NCHARS + 1;
`else
    localparam int LAST_CHAR = NCHARS - 1;
`endif

    localparam logic [IDX_W-1:0] LAST_IDX       = IDX_W'(LAST_CHAR);
    localparam logic [IDX_W-1:0] LAST_DIGIT_IDX = IDX_W'(NCHARS - 1);
    localparam logic [IDX_W-1:0] CR_IDX         = IDX_W'(NCHARS);
    localparam logic [IDX_W-1:0] LF_IDX         = IDX_W'(NCHARS + 1);
    localparam logic [7:0]       LETTER_BASE    = (LOWER != 0) ? 8'h61 : 8'h41;
    localparam bit               SKIP_EN        = (SUPPRESS_ZEROS != 0);

    generate
        if ((DATA_W < 4) || ((DATA_W % 4) != 0)) begin : g_bad_width
            $error("hex_word_tx: DATA_W must be a multiple of 4 and at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        SEND,
        WAIT
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_d;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] word_d;
    logic              nonzero_seen;
    logic              nonzero_seen_d;
    logic [7:0]        tx_data_d;
    logic              tx_en_d;

    logic [DATA_W-1:0] shifted;
    logic [3:0]        nibble;
    logic [7:0]        cur_char;
    logic              is_digit;
    logic              skip_digit;
    logic              accept;

    assign idle     = (state == IDLE);
    assign in_ready = (state == IDLE) && !RST;
    assign accept   = in_valid && in_ready;

    // Shifting the current nibble to the top avoids a part-select that could go out of range past the digits.
    assign shifted  = word_q << {idx, 2'b00};
    assign nibble   = shifted[DATA_W-1 -: 4];
    assign is_digit = (idx < CR_IDX);

    assign skip_digit = SKIP_EN && is_digit && (nibble == 4'h0) &&
                        (idx != LAST_DIGIT_IDX) && !nonzero_seen;

    always_comb begin
        cur_char = 8'h00;
        if (idx == CR_IDX) begin
            cur_char = 8'h0D;
        end else if (idx == LF_IDX) begin
            cur_char = 8'h0A;
        end else if (nibble < 4'd10) begin
            cur_char = 8'h30 + {4'h0, nibble};
        end else begin
            cur_char = LETTER_BASE + {4'h0, nibble} - 8'd10;
        end
    end

    always_comb begin
        state_d        = state;
        idx_d          = idx;
        word_d         = word_q;
        nonzero_seen_d = nonzero_seen;
        tx_data_d      = tx_data;
        tx_en_d        = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    word_d         = in_data;
                    idx_d          = '0;
                    nonzero_seen_d = 1'b0;
                    state_d        = ARM;
                end
            end
            // Busy must be low before starting, so a frame still in flight is never taken as the acknowledge.
            ARM: begin
                if (!tx_busy) begin
                    if (skip_digit) begin
                        idx_d = idx + 1'b1;
                    end else begin
                        tx_data_d      = cur_char;
                        tx_en_d        = 1'b1;
                        nonzero_seen_d = 1'b1;
                        state_d        = SEND;
                    end
                end
            end
            SEND: begin
                if (tx_busy) begin
                    state_d = WAIT;
                end else begin
                    tx_en_d = 1'b1;
                end
            end
            WAIT: begin
                if (!tx_busy) begin
                    if (idx == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx + 1'b1;
                        state_d = ARM;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            idx          <= '0;
            word_q       <= '0;
            nonzero_seen <= 1'b0;
            tx_data      <= 8'h00;
            tx_en        <= 1'b0;
        end else begin
            state        <= state_d;
            idx          <= idx_d;
            word_q       <= word_d;
            nonzero_seen <= nonzero_seen_d;
            tx_data      <= tx_data_d;
            tx_en        <= tx_en_d;
        end
    end

endmodule

// File: tb/tb_hex_word_tx.sv
// tb_hex_word_tx: three formatter configurations, each behind a simple uart_tx busy model,
// with a shared scoreboard queue of expected characters.
module tb_hex_word_tx;

`ifdef HEX_WORD_TX_CRLF_EN
    localparam int NTERM = 2;
`else
    localparam int NTERM = 0;
`endif

    typedef struct {
        int              inst;
        logic [15:0]     data;
        int              n;
        logic [0:3][7:0] ch;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid   [3];
    logic        in_ready   [3];
    logic [15:0] in_data    [3];
    logic [7:0]  tx_data    [3];
    logic        tx_en      [3];
    logic        tx_busy    [3];
    logic        idle       [3];
    logic        force_busy [3];
    int          busy_cnt   [3];

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    vec_t        vecs[11];

    always #5 CLK = ~CLK;

    hex_word_tx #(.DATA_W(8), .LOWER(0), .SUPPRESS_ZEROS(0)) dut_w8 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0][7:0]), .tx_data(tx_data[0]), .tx_en(tx_en[0]),
        .tx_busy(tx_busy[0]), .idle(idle[0])
    );

    hex_word_tx #(.DATA_W(16), .LOWER(1), .SUPPRESS_ZEROS(0)) dut_w16_lower (
        .CLK(CLK), .RST(RST), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .tx_data(tx_data[1]), .tx_en(tx_en[1]),
        .tx_busy(tx_busy[1]), .idle(idle[1])
    );

    hex_word_tx #(.DATA_W(16), .LOWER(0), .SUPPRESS_ZEROS(1)) dut_w16_sz (
        .CLK(CLK), .RST(RST), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .tx_data(tx_data[2]), .tx_en(tx_en[2]),
        .tx_busy(tx_busy[2]), .idle(idle[2])
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            tx_busy[i] = (busy_cnt[i] != 0) || force_busy[i];
        end
    end

    // uart_tx model: a start is tx_en sampled high while idle; busy then holds for 10 cycles.
    always @(posedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            if (tx_en[i] && !tx_busy[i] && busy_cnt[i] == 0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_char inst %0d: got %0h expected none", i, tx_data[i]);
                end else begin
                    check_output($sformatf("char_inst%0d", i), 32'(tx_data[i]), 32'(exp_q.pop_front()));
                end
                busy_cnt[i] <= 10;
            end else if (busy_cnt[i] > 0) begin
                busy_cnt[i] <= busy_cnt[i] - 1;
            end
        end
    end

    task automatic push_chars(input int n, input logic [0:3][7:0] ch);
        for (int k = 0; k < n; k++) exp_q.push_back(ch[k]);
        if (NTERM != 0) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic apply_stimulus(input int inst, input logic [15:0] data, input int n, input logic [0:3][7:0] ch);
        int waited;
        waited = 0;
        while (!in_ready[inst] && waited < 3000) begin
            @(negedge CLK);
            waited++;
        end
        check_output($sformatf("ready_before_%0h", data), 32'(in_ready[inst]), 32'd1);
        in_data[inst]  = data;
        in_valid[inst] = 1'b1;
        push_chars(n, ch);
        @(negedge CLK);
        in_valid[inst] = 1'b0;
        check_output($sformatf("accepted_%0h", data), 32'(idle[inst]), 32'd0);
    endtask

    task automatic wait_done(input int inst, input string name);
        int waited;
        int ready_leak;
        waited     = 0;
        ready_leak = 0;
        while (!(exp_q.size() == 0 && idle[inst]) && waited < 3000) begin
            if (in_ready[inst]) ready_leak++;
            @(negedge CLK);
            waited++;
        end
        check_output({name, "_done"}, 32'(exp_q.size() == 0 && idle[inst]), 32'd1);
        check_output({name, "_ready_low"}, 32'(ready_leak), 32'd0);
    endtask

    initial begin
        int n;
        int en_seen;

        vecs[0]  = '{0, 16'h00A5, 2, {8'h41, 8'h35, 8'h00, 8'h00}};
        vecs[1]  = '{1, 16'hBEEF, 4, {8'h62, 8'h65, 8'h65, 8'h66}};
        vecs[2]  = '{2, 16'h00F3, 2, {8'h46, 8'h33, 8'h00, 8'h00}};
        vecs[3]  = '{2, 16'h0000, 1, {8'h30, 8'h00, 8'h00, 8'h00}};
        vecs[4]  = '{2, 16'h0103, 3, {8'h31, 8'h30, 8'h33, 8'h00}};
        vecs[5]  = '{0, 16'h003C, 2, {8'h33, 8'h43, 8'h00, 8'h00}};
        vecs[6]  = '{1, 16'h0A0F, 4, {8'h30, 8'h61, 8'h30, 8'h66}};
        vecs[7]  = '{2, 16'hFFFF, 4, {8'h46, 8'h46, 8'h46, 8'h46}};
        vecs[8]  = '{0, 16'h0009, 2, {8'h30, 8'h39, 8'h00, 8'h00}};
        vecs[9]  = '{2, 16'h0009, 1, {8'h39, 8'h00, 8'h00, 8'h00}};
        vecs[10] = '{1, 16'h1234, 4, {8'h31, 8'h32, 8'h33, 8'h34}};

        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]   = 1'b0;
            in_data[i]    = 16'h0000;
            force_busy[i] = 1'b0;
        end
        in_valid[0] = 1'b1;
        in_data[0]  = 16'h00FF;
        repeat (3) @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("rst_tx_en_%0d", i), 32'(tx_en[i]), 32'd0);
            check_output($sformatf("rst_tx_data_%0d", i), 32'(tx_data[i]), 32'h00);
            check_output($sformatf("rst_idle_%0d", i), 32'(idle[i]), 32'd1);
            check_output($sformatf("rst_ready_low_%0d", i), 32'(in_ready[i]), 32'd0);
        end
        in_valid[0] = 1'b0;
        RST = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("post_rst_ready_%0d", i), 32'(in_ready[i]), 32'd1);
        end
        check_output("valid_in_rst_ignored", 32'(idle[0]), 32'd1);
        repeat (3) @(negedge CLK);

        for (int v = 0; v < 11; v++) begin
            apply_stimulus(vecs[v].inst, vecs[v].data, vecs[v].n, vecs[v].ch);
            wait_done(vecs[v].inst, $sformatf("vec%0d", v));
            repeat (2) @(negedge CLK);
        end

        // Back-pressure: in_valid stays high across two words.
        in_data[0]  = 16'h0012;
        in_valid[0] = 1'b1;
        push_chars(2, {8'h31, 8'h32, 8'h00, 8'h00});
        @(negedge CLK);
        check_output("bp_first_accept", 32'(idle[0]), 32'd0);
        in_data[0] = 16'h0034;
        push_chars(2, {8'h33, 8'h34, 8'h00, 8'h00});
        n = 0;
        while (!in_ready[0] && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        check_output("bp_ready_seen", 32'(in_ready[0]), 32'd1);
        check_output("bp_idle_with_ready", 32'(idle[0]), 32'd1);
        check_output("bp_first_word_sent", 32'(exp_q.size()), 32'(2 + NTERM));
        @(negedge CLK);
        in_valid[0] = 1'b0;
        check_output("bp_second_accept", 32'(idle[0]), 32'd0);
        wait_done(0, "bp");
        repeat (2) @(negedge CLK);

        // tx_busy forced high at accept for 20 cycles.
        force_busy[0] = 1'b1;
        in_data[0]    = 16'h00A5;
        in_valid[0]   = 1'b1;
        push_chars(2, {8'h41, 8'h35, 8'h00, 8'h00});
        @(negedge CLK);
        in_valid[0] = 1'b0;
        en_seen = 0;
        repeat (19) begin
            if (tx_en[0]) en_seen++;
            @(negedge CLK);
        end
        check_output("busy_hold_no_en", 32'(en_seen), 32'd0);
        force_busy[0] = 1'b0;
        check_output("busy_fall_en_low", 32'(tx_en[0]), 32'd0);
        @(negedge CLK);
        check_output("busy_fall_en_next", 32'(tx_en[0]), 32'd1);
        wait_done(0, "busy_force");
        repeat (2) @(negedge CLK);

        // Reset pulse during WAIT of the first digit abandons the word.
        apply_stimulus(0, 16'h00A5, 2, {8'h41, 8'h35, 8'h00, 8'h00});
        n = 0;
        while (!(tx_busy[0] && !tx_en[0] && !idle[0]) && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        check_output("rst_mid_in_wait", 32'(tx_busy[0] && !tx_en[0] && !idle[0]), 32'd1);
        check_output("rst_mid_first_sent", 32'(exp_q.size()), 32'(1 + NTERM));
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check_output("rst_mid_tx_en", 32'(tx_en[0]), 32'd0);
        check_output("rst_mid_idle", 32'(idle[0]), 32'd1);
        exp_q.delete();
        repeat (40) @(negedge CLK);
        check_output("rst_mid_still_idle", 32'(idle[0]), 32'd1);
        apply_stimulus(0, 16'h003C, 2, {8'h33, 8'h43, 8'h00, 8'h00});
        wait_done(0, "after_rst");
        repeat (20) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
